fpu_arbiter: RTL and testbench

Round-robin scheduler that shares one FPU adder instance among `N_REQ` requesters. It accepts operand pairs over a valid/ready handshake and restarts the FPU for each operation. It waits the FPU's fixed latency, captures `data_out`/`status_out`, and returns them to the granted requester over a response handshake. It sits between the requesting units and the `FPU` block, and is the only driver of the FPU's ports.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/fpu_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU arbiter. These are the float word layout
// (1 sign / 6 exponent / 25 mantissa, exponent bias 31), the FPU status word
// type, and the arbiter FSM state encoding.
// No ports; imported by fpu_arbiter and rr_arbiter.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 6;
  localparam int unsigned MANT_W   = 25;
  localparam int unsigned EXP_BIAS = 31;
  localparam int unsigned WORD_W   = SIGN_W + EXP_W + MANT_W;
  localparam int unsigned STATUS_W = 4;

  // Float word as seen on the operand and result buses
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fpu_float_t;

  // FPU status word; the arbiter carries it through without interpreting it
  typedef logic [STATUS_W-1:0] fpu_status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage : fpu_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. It searches req starting at ptr,
// wraps around, and returns a one-hot grant for the first active line
// (all-zero when nothing is requested).
// Ports:
//   req   in  N_REQ          request lines
//   ptr   in  clog2(N_REQ)   highest-priority index for this pick
//   grant out N_REQ          one-hot winner, or zero
// -----------------------------------------------------------------------------
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Rotating priority scan: position i of the scan is line (ptr + i) mod N_REQ
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Shares one fixed-latency FPU adder among N_REQ requesters. An operation is
// accepted over req_valid/req_ready using a round-robin grant. The block then
// pulses the FPU reset for one cycle with the operands applied, and waits
// FPU_LATENCY cycles. It captures the FPU result and status and returns them
// to the granted requester over rsp_valid/rsp_ready.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   req_valid/req_ready       per-requester request handshake (ready is
//                             combinational, one-hot or zero, IDLE only)
//   req_op_a/req_op_b         per-requester operand pairs
//   rsp_valid/rsp_ready       per-requester response handshake
//   rsp_data/rsp_status       shared captured result and FPU status
//   fpu_reset_n               FPU active-low reset, low one cycle per op
//   fpu_op_a/fpu_op_b         operands to the FPU
//   fpu_data_in/fpu_status_in result and status from the FPU
//   busy                      high whenever the FSM is not IDLE
//   ops_done                  completed responses, wraps
// -----------------------------------------------------------------------------
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FPU_LATENCY = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clock,
  input  logic                          reset,

  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][WORD_W-1:0]  req_op_a,
  input  logic [N_REQ-1:0][WORD_W-1:0]  req_op_b,

  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [WORD_W-1:0]             rsp_data,
  output logic [STATUS_W-1:0]           rsp_status,

  output logic                          fpu_reset_n,
  output logic [WORD_W-1:0]             fpu_op_a,
  output logic [WORD_W-1:0]             fpu_op_b,
  input  logic [WORD_W-1:0]             fpu_data_in,
  input  logic [STATUS_W-1:0]           fpu_status_in,

  output logic                          busy,
  output logic [CNT_W-1:0]              ops_done
);

  localparam int unsigned PTR_W     = $clog2(N_REQ);
  // +1 keeps the counter at least one bit wide when FPU_LATENCY is 1
  localparam int unsigned LAT_W     = $clog2(FPU_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FPU_LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [LAT_W-1:0] cnt;

  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             req_fire;
  logic             rsp_fire;

  // Round-robin pick among the current requests
  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Accept is offered only while idle and never during reset
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign req_fire  = |(req_valid & req_ready);
  assign rsp_fire  = (state == RESP) && rsp_ready[gnt_idx];

  // One-hot grant to index, used to latch the winner's operands and id
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[PTR_W'(i)]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Control FSM with all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_idx     <= '0;
      cnt         <= '0;
      ops_done    <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      fpu_reset_n <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fpu_reset_n <= 1'b1;
          if (req_fire) begin
            gnt_idx     <= grant_idx;
            fpu_op_a    <= req_op_a[grant_idx];
            fpu_op_b    <= req_op_b[grant_idx];
            // Restart the FPU for exactly the LOAD cycle
            fpu_reset_n <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end

        LOAD: begin
          fpu_reset_n <= 1'b1;
          cnt         <= '0;
          state       <= WAIT;
        end

        WAIT: begin
          if (cnt == LAT_LAST) begin
            rsp_data   <= fpu_data_in;
            rsp_status <= fpu_status_in;
            rsp_valid  <= N_REQ'(1) << gnt_idx;
            state      <= RESP;
          end else begin
            cnt <= cnt + LAT_W'(1);
          end
        end

        RESP: begin
          // Outputs stay frozen until the granted requester accepts
          if (rsp_fire) begin
            rsp_valid <= '0;
            ptr       <= (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);
            ops_done  <= ops_done + CNT_W'(1);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : fpu_arbiter

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
// Self-checking bench for fpu_arbiter with a behavioural FPU adder attached.
// It runs a table of single operations, hand sequences for contention,
// backpressure, mid-operation reset and counter wrap, and a randomized phase
// checked against a transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int CW = 4;

  typedef logic [1:0] rid_t;

  typedef struct packed {
    rid_t        r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][31:0]    req_op_a;
  logic [N-1:0][31:0]    req_op_b;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_status;
  logic                  fpu_reset_n;
  logic [31:0]           fpu_op_a;
  logic [31:0]           fpu_op_b;
  logic [31:0]           fpu_data_in;
  logic [3:0]            fpu_status_in;
  logic                  busy;
  logic [CW-1:0]         ops_done;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;
  int model_ops   = 0;
  int fcnt        = 0;

  always #5 clock = ~clock;

  fpu_arbiter #(
    .N_REQ       (N),
    .FPU_LATENCY (L),
    .CNT_W       (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_a      (req_op_a),
    .req_op_b      (req_op_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .fpu_reset_n   (fpu_reset_n),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .busy          (busy),
    .ops_done      (ops_done)
  );

  // Behavioural 1/6/25 adder (truncating). Status: [0] zero, [1] overflow,
  // [2] underflow.
  function automatic logic [35:0] fpu_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic        sx, sy;
    int          ex, ey, sh;
    logic [26:0] mx, my, mr;
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    sx = x[31];
    sy = y[31];
    ex = int'(x[30:25]);
    ey = int'(y[30:25]);
    mx = (ex == 0) ? 27'd0 : {2'b01, x[24:0]};
    my = (ey == 0) ? 27'd0 : {2'b01, y[24:0]};
    sh = ex - ey;
    my = (sh > 26) ? 27'd0 : (my >> sh);
    mr = (sx == sy) ? (mx + my) : (mx - my);
    if (mr == 27'd0) return {4'b0001, 32'h0};
    if (mr[26]) begin
      mr = mr >> 1;
      ex = ex + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!mr[25]) begin
        mr = mr << 1;
        ex = ex - 1;
      end
    end
    if (ex > 63) return {4'b0010, sx, 6'h3F, 25'h0};
    if (ex < 1)  return {4'b0100, 32'h0};
    return {4'b0000, sx, 6'(ex), mr[24:0]};
  endfunction

  // FPU latency model: output is garbage until L-1 cycles after reset release
  always @(posedge clock) begin
    if (!fpu_reset_n)   fcnt <= 0;
    else if (fcnt < 1000) fcnt <= fcnt + 1;
  end
  assign {fpu_status_in, fpu_data_in} =
    (fcnt >= L - 1) ? fpu_add(fpu_op_a, fpu_op_b) : {4'hF, 32'hDEADBEEF};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Round-robin rule: first active line searching from ptr, wrapping
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (bitof(v, (p + i) % N)) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input rid_t r, input logic [31:0] a, input logic [31:0] b);
    req_op_a[r]  = a;
    req_op_b[r]  = b;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    model_ptr = 0;
    model_ops = 0;
  endtask

  // One complete transaction from the IDLE cycle, checked against the model
  task automatic serve_one(input int hold, output int g,
                           output logic [31:0] got_data, output logic [3:0] got_status);
    int          n;
    logic        bad;
    rid_t        gi;
    logic [31:0] a, b, d0;
    logic [3:0]  s0;
    logic [35:0] ref_w;
    #1;
    g  = rr_pick(req_valid, model_ptr);
    gi = rid_t'(g);
    check("req_ready_grant", 64'(req_ready), 64'(onehot(g)));
    a     = req_op_a[gi];
    b     = req_op_b[gi];
    ref_w = fpu_add(a, b);
    tick();
    req_valid[gi] = 1'b0;
    check("load_fpu_reset_n", 64'(fpu_reset_n), 64'(0));
    check("load_busy", 64'(busy), 64'(1));
    check("load_req_ready", 64'(req_ready), 64'(0));
    check("load_fpu_op_a", 64'(fpu_op_a), 64'(a));
    check("load_fpu_op_b", 64'(fpu_op_b), 64'(b));
    n   = 0;
    bad = 1'b0;
    while (rsp_valid == '0 && n < L + 4) begin
      tick();
      n++;
      if (rsp_valid == '0 && (fpu_reset_n !== 1'b1 || req_ready !== '0 || busy !== 1'b1))
        bad = 1'b1;
    end
    check("wait_ctrl", 64'(bad), 64'(0));
    check("rsp_latency", 64'(n), 64'(L + 1));
    check("rsp_valid", 64'(rsp_valid), 64'(onehot(g)));
    check("rsp_data", 64'(rsp_data), 64'(ref_w[31:0]));
    check("rsp_status", 64'(rsp_status), 64'(ref_w[35:32]));
    got_data   = rsp_data;
    got_status = rsp_status;
    d0  = rsp_data;
    s0  = rsp_status;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~onehot(g);
      tick();
      if (rsp_valid !== onehot(g) || rsp_data !== d0 || rsp_status !== s0 ||
          req_ready !== '0 || busy !== 1'b1 || fpu_op_a !== a)
        bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", 64'(bad), 64'(0));
    rsp_ready = onehot(g);
    tick();
    rsp_ready = '0;
    model_ptr = (g + 1) % N;
    model_ops = model_ops + 1;
    check("rsp_valid_clear", 64'(rsp_valid), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("ops_done", 64'(ops_done), 64'(model_ops % (1 << CW)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          g;
    logic [31:0] d;
    logic [3:0]  s;
    logic        bad;

    vecs[0] = '{2'd0, 32'hBE000000, 32'hBE000000, 32'hC0000000, 4'h0};
    vecs[1] = '{2'd1, 32'h40000000, 32'hC2000000, 32'hC0000000, 4'h0};
    vecs[2] = '{2'd2, 32'h7F000000, 32'h7F000000, 32'h7E000000, 4'h2};
    vecs[3] = '{2'd3, 32'h3E000000, 32'hBE000000, 32'h00000000, 4'h1};
    vecs[4] = '{2'd0, 32'h3F000000, 32'h3C000000, 32'h40000000, 4'h0};
    vecs[5] = '{2'd1, 32'h3E000000, 32'h3E000000, 32'h40000000, 4'h0};

    // Reset: requests present but nothing may be accepted
    reset     = 1'b1;
    req_valid = '1;
    req_op_a  = '0;
    req_op_b  = '0;
    rsp_ready = '0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_status", 64'(rsp_status), 64'(0));
    check("rst_fpu_ops", 64'({fpu_op_a, fpu_op_b}), 64'(0));
    check("rst_fpu_reset_n", 64'(fpu_reset_n), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ops_done", 64'(ops_done), 64'(0));
    req_valid = '0;
    reset     = 1'b0;
    tick();
    check("idle_fpu_reset_n", 64'(fpu_reset_n), 64'(1));

    // Table of single operations
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].r, vecs[i].a, vecs[i].b);
      serve_one(0, g, d, s);
      check("tbl_grant", 64'(g), 64'(vecs[i].r));
      check("tbl_data", 64'(d), 64'(vecs[i].exp_data));
      check("tbl_status", 64'(s), 64'(vecs[i].exp_status));
    end

    // Contention: all four together from ptr 0
    do_reset();
    set_req(2'd0, 32'h3E000000, 32'h3E000000);
    set_req(2'd1, 32'h40000000, 32'hC2000000);
    set_req(2'd2, 32'hBE000000, 32'hBE000000);
    set_req(2'd3, 32'h3F000000, 32'h3C000000);
    for (int i = 0; i < N; i++) begin
      serve_one(0, g, d, s);
      check("contention_order", 64'(g), 64'(i));
      if (i == 1) check("contention_req1", 64'(d), 64'(32'hC0000000));
    end
    set_req(2'd0, 32'h3E000000, 32'h3E000000);
    set_req(2'd3, 32'hBE000000, 32'h3E000000);
    serve_one(0, g, d, s);
    check("ptr_wrapped", 64'(g), 64'(0));

    // Backpressure: req2 held in RESP while req3 waits
    set_req(2'd2, 32'h40000000, 32'h40000000);
    serve_one(5, g, d, s);
    check("bp_grant", 64'(g), 64'(2));
    serve_one(0, g, d, s);
    check("bp_next_grant", 64'(g), 64'(3));

    // Reset during WAIT at cnt = 4
    do_reset();
    set_req(2'd1, 32'h3E000000, 32'h3E000000);
    #1;
    check("mid_rst_grant", 64'(req_ready), 64'(onehot(1)));
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_fpu_reset_n", 64'(fpu_reset_n), 64'(0));
    check("mid_rst_fpu_ops", 64'({fpu_op_a, fpu_op_b}), 64'(0));
    check("mid_rst_rsp", 64'({rsp_data, rsp_status}), 64'(0));
    check("mid_rst_ops_done", 64'(ops_done), 64'(0));
    reset = 1'b0;
    bad   = 1'b0;
    for (int i = 0; i < L + 4; i++) begin
      tick();
      if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    check("mid_rst_no_rsp", 64'(bad), 64'(0));
    model_ptr = 0;
    model_ops = 0;

    // Randomized traffic against the round-robin model
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < N; r++) begin
        if (!req_valid[rid_t'(r)] && $urandom_range(0, 1) == 1)
          set_req(rid_t'(r), $urandom(), $urandom());
      end
      if ($urandom_range(0, 5) == 0) req_valid[rid_t'($urandom_range(0, N - 1))] = 1'b0;
      if (req_valid == '0) set_req(rid_t'($urandom_range(0, N - 1)), $urandom(), $urandom());
      serve_one(int'($urandom_range(0, 3)), g, d, s);
    end

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_req(2'd0, $urandom(), $urandom());
      serve_one(0, g, d, s);
    end
    check("ops_done_wrap", 64'(ops_done), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fpu_arbiter
